pipe_barrel_shifter: RTL and testbench
======================================

PIPE_BARREL_SHIFTER -- requirements
Module: pipe_barrel_shifter

Interface
REQ-001 Parameter: WIDTH, default 32, data width; SHALL be a power of two, minimum 4.
REQ-002 Parameter: SW, default $clog2(WIDTH), shift-amount width and pipeline stage count; derived, not overridden.
REQ-003 clk  input  1  the block's only clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  the operand on a/s/mode is valid this cycle.
REQ-006 a  input  WIDTH  operand.
REQ-007 s  input  SW  shift amount, unsigned, 0..WIDTH-1.
REQ-008 mode  input  2  operation: 00 SRL, 01 SRA, 10 SLL, 11 ROR.
REQ-009 stall  input  1  when high, all pipeline registers SHALL hold and inputs SHALL be ignored.
REQ-010 out_valid  output  1  o holds a completed result.
REQ-011 o  output  WIDTH  shifted result, registered.

Function
REQ-012 The pipeline SHALL have SW stages; stage k (k=0..SW-1) SHALL apply a conditional shift of 2^(SW-1-k) controlled by s[SW-1-k], with the largest distance first.
REQ-013 Each stage SHALL register its data, valid bit, mode and the not-yet-consumed shift-amount bits; control bits SHALL travel with their data.
REQ-014 Latency SHALL be exactly SW unstalled cycles: an operand accepted at edge n SHALL appear on o with out_valid=1 after edge n+SW-1 (o driven by the last stage register).
REQ-015 Throughput SHALL be one operand per cycle; consecutive operands MAY use different mode and s values with no bubble.
REQ-016 SRL SHALL fill vacated positions with 0; SRA SHALL fill with a[WIDTH-1] of the original operand; SLL SHALL fill with 0; ROR SHALL wrap bits shifted out of bit 0 into bit WIDTH-1.
REQ-017 s=0 SHALL return a unchanged in every mode.
REQ-018 in_valid=0 SHALL insert a bubble: valid=0 propagates and out_valid deasserts SW cycles later; o contents under out_valid=0 are don't-care.
REQ-019 stall=1 SHALL freeze every stage register and out_valid/o; an operand presented while stall=1 SHALL be dropped, not accepted.
REQ-020 rst and stall asserted together: rst SHALL take priority.

Reset
REQ-021 On rst=1 at a clock edge, every stage valid bit and out_valid SHALL become 0 and o SHALL become 0 on that edge.
REQ-022 Reset mid-operation SHALL discard all in-flight operands; none SHALL emerge after reset deasserts.
REQ-023 An operand with in_valid=1 in the first cycle after rst deasserts SHALL be accepted normally.

Structure
REQ-024 A shared package SHALL hold the mode encoding (SRL/SRA/SLL/ROR enum) and the WIDTH-to-SW helper.
REQ-025 One sub-module, shift_stage, SHALL implement a single parameterised conditional-shift-plus-register stage (parameter: shift distance); the top SHALL generate SW instances.

Verification (WIDTH=32, latency 5)
REQ-026 SRL a=0x80000000 s=31 -> o=0x00000001, out_valid after 5 cycles; SRA a=0x80000000 s=4 -> 0xF8000000.
REQ-027 SLL a=0x00000001 s=31 -> 0x80000000; ROR a=0x00000001 s=1 -> 0x80000000; any mode s=0 a=0xDEADBEEF -> 0xDEADBEEF.
REQ-028 Back-to-back stream of 64 random operands cycling all four modes -> results in order, one per cycle, matching a reference model.
REQ-029 stall held 3 cycles mid-stream -> o/out_valid frozen, no operand lost or duplicated, stream resumes in order.
REQ-030 rst pulsed with 3 operands in flight -> out_valid=0, o=0 next cycle, no stale result emerges; new operand after reset returns correct after 5 cycles.
REQ-031 Alternating in_valid 1/0 -> out_valid alternates identically, delayed by 5 cycles.

Source files
------------

// File: rtl/pipe_barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//   shift_mode_e : operation encoding carried down the pipeline with each operand
//   width_to_sw  : number of shift-amount bits (and pipeline stages) for a data width
package pipe_barrel_shifter_pkg;

  typedef enum logic [1:0] {
    MODE_SRL = 2'b00,  // logical right, zero fill
    MODE_SRA = 2'b01,  // arithmetic right, sign fill
    MODE_SLL = 2'b10,  // logical left, zero fill
    MODE_ROR = 2'b11   // rotate right
  } shift_mode_e;

  function automatic int width_to_sw(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/pipe_barrel_shifter_shift_stage.sv
// shift_stage: one pipeline stage of the barrel shifter. Conditionally shifts
// the incoming word by the fixed distance DIST (when the matching shift-amount
// bit is set) and registers the result together with its control.
//   clk, rst            : clock, synchronous active-high reset
//   stall               : hold all registers
//   valid_in / _out     : operand valid travelling with the data
//   data_in / data_out  : partially shifted word
//   mode_in / mode_out  : operation for this operand
//   s_in / s_out        : shift amount for this operand
module shift_stage
  import pipe_barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SW    = 5,
  parameter int DIST  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  input  shift_mode_e      mode_in,
  input  logic [SW-1:0]    s_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out,
  output shift_mode_e      mode_out,
  output logic [SW-1:0]    s_out
);

  // The shift-amount bit that selects this stage's distance.
  localparam int SBIT = $clog2(DIST);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;
  shift_mode_e      mode_reg;
  logic [SW-1:0]    s_reg;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] data_next;

  always_comb begin
    shifted = data_in;
    unique case (mode_in)
      MODE_SRL: shifted = data_in >> DIST;
      // Earlier stages preserve the MSB under SRA, so data_in[WIDTH-1] is
      // still the sign of the original operand.
      MODE_SRA: shifted = $signed(data_in) >>> DIST;
      MODE_SLL: shifted = data_in << DIST;
      MODE_ROR: shifted = (data_in >> DIST) | (data_in << (WIDTH - DIST));
      default:  shifted = data_in;
    endcase
    data_next = s_in[SBIT] ? shifted : data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      mode_reg  <= MODE_SRL;
      s_reg     <= '0;
    end else if (!stall) begin
      valid_reg <= valid_in;
      data_reg  <= data_next;
      mode_reg  <= mode_in;
      s_reg     <= s_in;
    end
  end

  assign valid_out = valid_reg;
  assign data_out  = data_reg;
  assign mode_out  = mode_reg;
  assign s_out     = s_reg;

endmodule

// File: rtl/pipe_barrel_shifter.sv
// pipe_barrel_shifter: SW-stage pipelined barrel shifter (SRL/SRA/SLL/ROR),
// one operand per cycle, latency SW cycles, largest shift distance first.
//   clk       : clock
//   rst       : synchronous active-high reset (wins over stall)
//   in_valid  : a/s/mode carry an operand this cycle
//   a         : operand
//   s         : shift amount 0..WIDTH-1
//   mode      : 00 SRL, 01 SRA, 10 SLL, 11 ROR
//   stall     : freeze the whole pipeline; a presented operand is dropped
//   out_valid : o holds a completed result
//   o         : result, driven straight from the last stage register
module pipe_barrel_shifter
  import pipe_barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SW    = width_to_sw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [SW-1:0]    s,
  input  logic [1:0]       mode,
  input  logic             stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] o
);

  // Entry 0 is the pipeline input; entry gi+1 is the register of stage gi.
  logic [SW:0]      valid_pipe;
  logic [WIDTH-1:0] data_pipe [SW+1];
  shift_mode_e      mode_pipe [SW+1];
  logic [SW-1:0]    s_pipe    [SW+1];

  assign valid_pipe[0] = in_valid;
  assign data_pipe[0]  = a;
  assign mode_pipe[0]  = shift_mode_e'(mode);
  assign s_pipe[0]     = s;

  generate
    for (genvar gi = 0; gi < SW; gi++) begin : g_stage
      shift_stage #(
        .WIDTH (WIDTH),
        .SW    (SW),
        .DIST  (1 << (SW - 1 - gi))
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .valid_in  (valid_pipe[gi]),
        .data_in   (data_pipe[gi]),
        .mode_in   (mode_pipe[gi]),
        .s_in      (s_pipe[gi]),
        .valid_out (valid_pipe[gi+1]),
        .data_out  (data_pipe[gi+1]),
        .mode_out  (mode_pipe[gi+1]),
        .s_out     (s_pipe[gi+1])
      );
    end
  endgenerate

  assign out_valid = valid_pipe[SW];
  assign o         = data_pipe[SW];

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Self-checking bench for pipe_barrel_shifter (WIDTH=32, latency 5).
// Reference: results computed arithmetically per operand and delayed through
// a 5-slot expectation line that advances on every unstalled, unreset edge.
module tb_pipe_barrel_shifter;
  import pipe_barrel_shifter_pkg::*;

  localparam int WIDTH = 32;
  localparam int SW    = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [SW-1:0]    s;
  logic [1:0]       mode;
  logic             stall;
  logic             out_valid;
  logic [WIDTH-1:0] o;

  always #5 clk = ~clk;

  pipe_barrel_shifter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .s         (s),
    .mode      (mode),
    .stall     (stall),
    .out_valid (out_valid),
    .o         (o)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  logic             exp_v [SW];
  logic [WIDTH-1:0] exp_d [SW];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s cycle %0d: got 0x%08h want 0x%08h", tag, cyc, got, want);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [31:0] x, input int sh, input logic [1:0] m);
    logic [63:0]        dbl;
    logic signed [31:0] sx;
    dbl = {x, x} >> sh;
    sx  = x;
    case (m)
      2'b00:   return x >> sh;
      2'b01:   return sx >>> sh;
      2'b10:   return x << sh;
      default: return dbl[31:0];
    endcase
  endfunction

  // One clock: advance the expectation line with what the DUT sees at this
  // edge, then check the outputs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst) begin
      for (int i = 0; i < SW; i++) exp_v[i] = 1'b0;
    end else if (!stall) begin
      for (int i = SW - 1; i > 0; i--) begin
        exp_v[i] = exp_v[i-1];
        exp_d[i] = exp_d[i-1];
      end
      exp_v[0] = in_valid;
      exp_d[0] = ref_op(a, int'(s), mode);
    end
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_v[SW-1]});
    if (rst) check("rst_o", o, 32'd0);
    else if (exp_v[SW-1]) begin
      check("o", o, exp_d[SW-1]);
      $display("cycle %0d: result o=0x%08h", cyc, o);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] x, input int sh, input logic [1:0] m);
    logic [31:0] sh_v;
    sh_v     = sh;
    in_valid = v;
    a        = x;
    s        = sh_v[SW-1:0];
    mode     = m;
  endtask

  task automatic drive_rand(input logic v, input logic [1:0] m);
    drive(v, $urandom, int'($urandom_range(0, WIDTH - 1)), m);
  endtask

  // Single operand followed by bubbles; result must appear after edge n+4.
  task automatic directed(input string tag, input logic [31:0] x, input int sh,
                          input logic [1:0] m, input logic [31:0] want);
    drive(1'b1, x, sh, m);
    tick();
    in_valid = 1'b0;
    repeat (SW - 1) tick();
    check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    check(tag, o, want);
  endtask

  logic [31:0] o_hold;

  initial begin
    for (int i = 0; i < SW; i++) begin
      exp_v[i] = 1'b0;
      exp_d[i] = '0;
    end
    rst = 1'b1; stall = 1'b0;
    drive(1'b0, 32'd0, 0, 2'b00);
    repeat (3) tick();
    check("reset_vld", {31'd0, out_valid}, 32'd0);
    check("reset_o", o, 32'd0);
    rst = 1'b0;

    // Directed boundary cases.
    directed("srl31",    32'h8000_0000, 31, 2'b00, 32'h0000_0001);
    directed("sra4",     32'h8000_0000, 4,  2'b01, 32'hF800_0000);
    directed("sll31",    32'h0000_0001, 31, 2'b10, 32'h8000_0000);
    directed("ror1",     32'h0000_0001, 1,  2'b11, 32'h8000_0000);
    for (int m = 0; m < 4; m++)
      directed("s0", 32'hDEAD_BEEF, 0, 2'(m), 32'hDEAD_BEEF);

    // Back-to-back random stream cycling all modes.
    for (int i = 0; i < 64; i++) begin
      drive_rand(1'b1, 2'(i % 4));
      tick();
    end
    in_valid = 1'b0;
    repeat (SW + 1) tick();

    // Stall for 3 cycles mid-stream; operands offered during stall are dropped.
    for (int i = 0; i < 10; i++) begin
      drive_rand(1'b1, 2'($urandom_range(0, 3)));
      tick();
    end
    o_hold = o;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1, 2'($urandom_range(0, 3)));
      tick();
      check("stall_o", o, o_hold);
      check("stall_vld", {31'd0, out_valid}, 32'd1);
    end
    stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_rand(1'b1, 2'($urandom_range(0, 3)));
      tick();
    end
    in_valid = 1'b0;
    repeat (SW + 1) tick();

    // Reset with 3 operands in flight, asserted together with stall.
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1, 2'(i));
      tick();
    end
    rst = 1'b1; stall = 1'b1;
    drive_rand(1'b1, 2'b01);
    tick();
    check("midrst_vld", {31'd0, out_valid}, 32'd0);
    check("midrst_o", o, 32'd0);
    rst = 1'b0; stall = 1'b0;
    directed("post_rst", 32'h1234_5678, 8, 2'b11, 32'h7812_3456);
    repeat (SW + 1) tick();

    // Alternating valid / bubble.
    for (int i = 0; i < 20; i++) begin
      drive_rand((i % 2) == 0, 2'($urandom_range(0, 3)));
      tick();
    end
    in_valid = 1'b0;
    repeat (SW + 1) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
